// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short, long and double presses,
// emitting a single-cycle tick per gesture from one shared cycle counter.
module press_classifier #(
  parameter int unsigned W          = 26,
  parameter int unsigned LONG_LIMIT = 50_000_000,
  parameter int unsigned GAP_LIMIT  = 15_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HELD,
    GAP,
    PRESS2
  } state_e;

  localparam logic [W-1:0] LONG_LAST = W'(LONG_LIMIT - 1);
  localparam logic [W-1:0] GAP_LAST  = W'(GAP_LIMIT - 1);
  localparam logic [W-1:0] CNT_ONE   = W'(1);

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    short_tick  = 1'b0;
    long_tick   = 1'b0;
    double_tick = 1'b0;

    case (state_q)
      IDLE: begin
        if (level) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (level) begin
          if (cnt_q == LONG_LAST) begin
            long_tick = 1'b1;
            state_d   = LONG_HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      LONG_HELD: begin
        if (!level) state_d = IDLE;
      end
      GAP: begin
        // A returning press wins over an expiring gap in the same cycle.
        if (level) begin
          double_tick = 1'b1;
          state_d     = PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          short_tick = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS2: begin
        if (!level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ticks stay combinational during reset; only the state is forced.
    if (reset) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: directed gesture table, reset corner cases and
// randomized level runs checked against a timestamp-based gesture model.
module tb_press_classifier;

  localparam int W     = 4;
  localparam int LONG  = 8;
  localparam int GAP   = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level = 1'b0;
  logic short_tick, long_tick, double_tick, busy;

  always #5 clk = ~clk;

  press_classifier #(
    .W         (W),
    .LONG_LIMIT(LONG),
    .GAP_LIMIT (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .level      (level),
    .short_tick (short_tick),
    .long_tick  (long_tick),
    .double_tick(double_tick),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Gesture model: remembers when the press began and when it was released,
  // and decides ticks from elapsed time since those moments.
  typedef enum {G_NONE, G_HOLDING, G_HELD_LONG, G_RELEASED, G_SECOND} gest_e;
  gest_e      g_phase = G_NONE;
  int         t_now   = 0;
  int         t_rise  = 0;
  int         t_fall  = 0;
  logic [2:0] m_ticks;   // {short, long, double}
  logic       m_busy;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t_now, act, exp);
    end
  endtask

  task automatic model_step(input logic lv, input logic rs);
    gest_e nxt;
    nxt     = g_phase;
    m_ticks = 3'b000;
    m_busy  = (g_phase != G_NONE);
    case (g_phase)
      G_NONE: if (lv) begin t_rise = t_now; nxt = G_HOLDING; end
      G_HOLDING: begin
        if (lv) begin
          if (t_now - t_rise == LONG) begin m_ticks = 3'b010; nxt = G_HELD_LONG; end
        end else begin
          t_fall = t_now;
          nxt = G_RELEASED;
        end
      end
      G_HELD_LONG: if (!lv) nxt = G_NONE;
      G_RELEASED: begin
        if (lv && (t_now - t_fall) >= 1 && (t_now - t_fall) <= GAP) begin
          m_ticks = 3'b001;
          nxt = G_SECOND;
        end else if (!lv && (t_now - t_fall) == GAP) begin
          m_ticks = 3'b100;
          nxt = G_NONE;
        end
      end
      G_SECOND: if (!lv) nxt = G_NONE;
      default: nxt = G_NONE;
    endcase
    if (rs) nxt = G_NONE;
    g_phase = nxt;
    t_now++;
  endtask

  // Drive one cycle's inputs, then compare against the model before the edge.
  task automatic step(input logic lv, input logic rs);
    @(negedge clk);
    level = lv;
    reset = rs;
    #1;
    model_step(lv, rs);
    check("busy_model", {7'd0, busy}, {7'd0, m_busy});
    if (!rs) check("ticks_model", {5'd0, short_tick, long_tick, double_tick}, {5'd0, m_ticks});
  endtask

  typedef struct {
    string name;
    int hi_a, hi_b, hi2_a, hi2_b, rst_at;
    int tk1, c1, tk2, c2;
    int busy_off;
  } vec_t;

  vec_t vecs[7];
  int   len;
  logic lv;
  logic rs;
  int   exp_mask;

  initial begin
    // mask: 4 = short, 2 = long, 1 = double
    vecs[0] = '{"short",   10, 13, -1, -1, -1, 4, 19, 0, -1, 20};
    vecs[1] = '{"long",    10, 30, -1, -1, -1, 2, 18, 0, -1, 32};
    vecs[2] = '{"bound8",  10, 17, -1, -1, -1, 4, 23, 0, -1, 24};
    vecs[3] = '{"bound9",  10, 18, -1, -1, -1, 2, 18, 0, -1, 20};
    vecs[4] = '{"double",  10, 12, 18, 20, -1, 1, 18, 0, -1, 22};
    vecs[5] = '{"late2nd", 10, 12, 19, 19, -1, 4, 18, 4, 25, 26};
    vecs[6] = '{"rstmid",  10, 30, -1, -1, 14, 2, 23, 0, -1, 32};

    // Reset held with level high: everything quiet until reset drops.
    step(1'b1, 1'b1);
    check("rst_outs0", {4'd0, short_tick, long_tick, double_tick, busy}, 8'd0);
    step(1'b1, 1'b1);
    check("rst_outs1", {4'd0, short_tick, long_tick, double_tick, busy}, 8'd0);
    step(1'b1, 1'b0);
    check("first_rise_busy", {7'd0, busy}, 8'd0);
    step(1'b1, 1'b0);
    check("busy_rises", {7'd0, busy}, 8'd1);

    foreach (vecs[v]) begin
      for (int c = 0; c < 40; c++) begin
        lv = ((c >= vecs[v].hi_a && c <= vecs[v].hi_b) ||
              (c >= vecs[v].hi2_a && c <= vecs[v].hi2_b));
        rs = (c < 2) || (c == vecs[v].rst_at);
        step(lv, rs);
        exp_mask = 0;
        if (c == vecs[v].c1) exp_mask = exp_mask | vecs[v].tk1;
        if (c == vecs[v].c2) exp_mask = exp_mask | vecs[v].tk2;
        if (!rs)
          check($sformatf("tbl_%s_c%0d", vecs[v].name, c),
                {5'd0, short_tick, long_tick, double_tick}, 8'(exp_mask));
        if (c == vecs[v].busy_off - 1)
          check($sformatf("tbl_%s_busy_hi", vecs[v].name), {7'd0, busy}, 8'd1);
        if (c == vecs[v].busy_off)
          check($sformatf("tbl_%s_busy_lo", vecs[v].name), {7'd0, busy}, 8'd0);
      end
    end

    // Randomized runs of constant level with rare resets.
    for (int g = 0; g < 400; g++) begin
      len = $urandom_range(1, 12);
      lv  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        rs = ($urandom_range(0, 199) == 0);
        step(lv, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
